// File: rtl/reset_seq_pkg.sv
// Shared constants for the reset sequencer: FSM state encodings and default timing.
package reset_seq_pkg;

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_PRE_CYCLES      = 10;
  localparam int DEF_PULSE_CYCLES    = 5;
  localparam int DEF_STAGGER_CYCLES  = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 16;

  // Channel index width: enough for the largest legal channel count (16).
  localparam int CH_IDX_W = 4;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus counting debouncer for the manual re-trigger button.
// Emits the stable level and a one-cycle pulse on each debounced rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iButton,
  output logic oLevel,
  output logic oPress
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= iButton;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any sample agreeing with the stable level restarts the count.
      if (r_sync2 != r_level) begin
        if (r_cnt >= C_LAST) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign oLevel = r_level;
  assign oPress = r_press;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / manual reset sequencer: idle, assert all channels, then release
// them one by one with a fixed stagger; a debounced button press re-runs it from DONE.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int PRE_CYCLES      = DEF_PRE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iButton,
  output logic [NUM_CH-1:0] oResetCh,
  output logic              oBusy,
  output logic              oDone,
  output logic [1:0]        oState
);

  localparam logic [CNT_W-1:0]    C_PRE_LAST   = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    C_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    C_STAG_LAST  = (STAGGER_CYCLES > 0) ? CNT_W'(STAGGER_CYCLES - 1) : '0;
  localparam logic [CH_IDX_W-1:0] C_LAST_CH    = CH_IDX_W'(NUM_CH - 1);
  localparam bit                  C_ALL_AT_ONCE = (STAGGER_CYCLES == 0) || (NUM_CH == 1);

  logic                w_level;
  logic                w_press;
  logic                w_press_ok;

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CH_IDX_W-1:0] r_idx;
  logic                r_rst_ch [NUM_CH];

  logic [1:0]          w_state_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [CH_IDX_W-1:0] w_idx_next;
  logic                w_set_all;
  logic [NUM_CH-1:0]   w_clr_mask;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_button (
    .Clock   (Clock),
    .Reset   (Reset),
    .iButton (iButton),
    .oLevel  (w_level),
    .oPress  (w_press)
  );

  // The press pulse and the new high level are registered together.
  assign w_press_ok = w_press & w_level;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + CNT_W'(1));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_cnt_inc;
    w_idx_next   = r_idx;
    w_set_all    = 1'b0;
    w_clr_mask   = '0;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt >= C_PRE_LAST) begin
          w_state_next = ST_ASSERT;
          w_cnt_next   = '0;
          w_set_all    = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (r_cnt >= C_PULSE_LAST) begin
          w_cnt_next = '0;
          if (C_ALL_AT_ONCE) begin
            w_clr_mask   = '1;
            w_state_next = ST_DONE;
          end else begin
            w_clr_mask   = NUM_CH'(1);
            w_idx_next   = CH_IDX_W'(1);
            w_state_next = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (r_cnt >= C_STAG_LAST) begin
          w_clr_mask = NUM_CH'(1) << r_idx;
          w_cnt_next = '0;
          if (r_idx >= C_LAST_CH) begin
            w_state_next = ST_DONE;
          end else begin
            w_idx_next = r_idx + CH_IDX_W'(1);
          end
        end
      end
      default: begin
        // DONE: only a debounced press restarts; presses elsewhere are dropped.
        if (w_press_ok) begin
          w_state_next = ST_ASSERT;
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_set_all    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_rst_ch[gi] <= 1'b0;
        end else if (w_set_all) begin
          r_rst_ch[gi] <= 1'b1;
        end else if (w_clr_mask[gi]) begin
          r_rst_ch[gi] <= 1'b0;
        end
      end
      assign oResetCh[gi] = r_rst_ch[gi];
    end
  endgenerate

  assign oState = r_state;
  assign oBusy  = (r_state != ST_DONE);
  assign oDone  = (r_state == ST_DONE);

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of sequenced reset channels, legal range 1..16.
REQ-002 Parameter PRE_CYCLES, default 10: idle cycles before the pulse asserts, minimum 1.
REQ-003 Parameter PULSE_CYCLES, default 5: cycles all channels are held asserted, minimum 1.
REQ-004 Parameter STAGGER_CYCLES, default 2: cycles between successive channel releases; 0 is legal.
REQ-005 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples needed to accept a button level change, minimum 1.
REQ-006 Parameter CNT_W, default 16: width of internal timing counters; every timing parameter SHALL fit in CNT_W bits.
REQ-007 Clock  input  1  single system clock; all logic is on the rising edge.
REQ-008 Reset  input  1  synchronous, active-high reset.
REQ-009 iButton  input  1  asynchronous manual re-trigger push-button, active-high.
REQ-010 oResetCh  output  NUM_CH  per-channel reset pulse, active-high, registered.
REQ-011 oBusy  output  1  high whenever the state is not DONE.
REQ-012 oDone  output  1  high in DONE.
REQ-013 oState  output  2  current state encoding, intended for LED display.

Function
REQ-014 The block SHALL run an FSM with the states WAIT=0, ASSERT=1, RELEASE=2 and DONE=3.
REQ-015 Edge numbering: n = 1 is the first rising edge with Reset sampled low; every output is registered and changes only on an edge.
REQ-016 WAIT: oResetCh = 0; after edge PRE_CYCLES the FSM enters ASSERT and oResetCh becomes all-ones.
REQ-017 ASSERT: oResetCh stays all-ones; after edge PRE_CYCLES+PULSE_CYCLES the FSM enters RELEASE and channel 0 clears.
REQ-018 RELEASE: channel k clears after edge PRE_CYCLES+PULSE_CYCLES+k*STAGGER_CYCLES; a cleared channel never reasserts until the next ASSERT.
REQ-019 With STAGGER_CYCLES = 0 all channels clear on the same edge and the FSM enters DONE directly.
REQ-020 The FSM SHALL enter DONE on the edge that clears channel NUM_CH-1, and oDone rises on that same edge.
REQ-021 With NUM_CH = 1, RELEASE lasts zero cycles and ASSERT goes straight to DONE.
REQ-022 iButton SHALL pass through a 2-flop synchronizer, then a debouncer that flips its stable level only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
REQ-023 A rising edge of the debounced level SHALL generate a one-cycle press event.
REQ-024 A press event in DONE: on the next edge the FSM enters ASSERT, oResetCh goes all-ones and oDone goes low, then the sequence follows REQ-017..020.
REQ-025 A press event in WAIT, ASSERT or RELEASE SHALL be ignored and discarded, not queued.
REQ-026 Counters SHALL saturate and never wrap; they clear on every state entry.

Reset
REQ-027 Reset high SHALL, on the sampling edge, force state WAIT, oResetCh = 0, oBusy = 1, oDone = 0, oState = 0, clear all counters and set the debounced level to 0.
REQ-028 Reset asserted mid-sequence SHALL abort immediately per REQ-027, and the full sequence restarts from WAIT after Reset is released.
REQ-029 A button held through Reset SHALL produce a press event after release; it is ignored unless the FSM has reached DONE.

Structure
REQ-030 The state encodings and the default timing constants SHALL live in a shared package, reset_seq_pkg.
REQ-031 The synchronizer and debouncer SHALL form one sub-module, button_debouncer (params DEBOUNCE_CYCLES, CNT_W; outputs level and press pulse).

Verification
REQ-032 Defaults, Reset for 5 cycles then released -> oResetCh all-ones after edge 10; ch0 clears at 15, ch1 at 17, ch2 at 19, ch3 at 21; oDone = 1 at 21.
REQ-033 In DONE, iButton high for 10 cycles -> press event about 2+4 edges later; next edge oResetCh = 4'b1111, oDone = 0; release pattern repeats at +5/+7/+9/+11.
REQ-034 iButton glitches of 1..3 cycles in DONE -> no press event and the state stays DONE.
REQ-035 Reset pulsed on edge 17 (ch0 cleared, ch1 still set) -> oResetCh = 0 and oState = 0 next edge; the full REQ-032 timeline repeats.
REQ-036 NUM_CH=8, STAGGER_CYCLES=0 -> all 8 channels clear together after edge 15 and DONE is reached at 15.
REQ-037 Press held during ASSERT -> ignored; the sequence completes on the REQ-032 timing and there is no re-trigger on entering DONE.
